mul_seq: RTL and testbench
==========================

// Module: mul_seq
// PURPOSE
//  Multi-cycle 32x32 multiply sequencer. It replaces the single-cycle 64-bit product in the EX stage for MULT/MULTU/MUL/MADD(U)/MSUB(U).
//  Each product is built over 4 cycles from 16x16 partial products.
//  EX drives start/operands and holds the pipeline stall while ready_o is low. Handshake is identical to the divider's.
//  annul_i comes from the pipeline flush.
// PARAMETERS
//  none (widths fixed by define.v: `RegBus 32b, `DoubleRegBus 64b)
// PORTS
//  clk           in   1   clock; single clock domain
//  rst           in   1   synchronous reset, active-high (`RstEnable)
//  signed_mul_i  in   1   1 = signed operands, 0 = unsigned
//  opdata1_i     in   32  multiplicand
//  opdata2_i     in   32  multiplier
//  start_i       in   1   `MulStart request; held high by EX until ready_o is seen
//  annul_i       in   1   abort the current operation (flush)
//  result_o      out  64  {HI,LO} product; valid when ready_o=1
//  ready_o       out  1   `MulResultReady / `MulResultNotReady
// BEHAVIOUR
//  Reset: rst=1 at a clk edge -> state MUL_FREE, result_o=0, ready_o=0, cnt=0, acc=0.
//   Priority is rst > annul_i > normal operation.
//  States: MUL_FREE, MUL_ON, MUL_END (2-bit encoding in define.v).
//  MUL_FREE, start_i=1, annul_i=0:
//   - latch magA=|opdata1_i| and magB=|opdata2_i|; abs is taken only when signed_mul_i=1 and bit31=1, via ~x+1.
//   - latch neg=signed_mul_i & (op1[31]^op2[31]).
//   - acc<=0, cnt<=0, go to MUL_ON.
//   - In MUL_FREE, result_o=0 and ready_o=0.
//  MUL_ON, one partial product per cycle, added into the 64b accumulator:
//   - cnt0: aL*bL
//   - cnt1: aH*bL<<16
//   - cnt2: aL*bH<<16
//   - cnt3: aH*bH<<32
//   - On the cnt3 cycle, register result_o = neg ? ~(acc+pp)+1 : acc+pp, set ready_o=1, go to MUL_END.
//   - Operands and start_i changes are ignored while in MUL_ON.
//  MUL_END:
//   - start_i=1: hold result_o and ready_o.
//   - start_i=0: go to MUL_FREE; ready_o=0 and result_o=0 on the next cycle.
//   - If start_i fell during MUL_ON, ready_o is high for exactly one cycle.
//  Latency: the edge sampling start_i=1 is edge 1. ready_o=1 after edge 5, so the EX stall is 5 cycles.
//   Back-to-back: a new op needs start_i low for 1 cycle, i.e. one MUL_FREE pass.
//  annul_i=1 in any state: next state MUL_FREE, ready_o=0, result_o=0, partial acc discarded.
//  Arithmetic: all partial products are unsigned 32b and acc is a 64b modulo sum; no overflow is possible.
//   0x80000000 magnitude is exact as unsigned.
// CONFIGURATION
//  `MUL_EARLY_OUT_EN defined:
//   - If latched aH==0 and bH==0, MUL_ON runs cnt0 only and enters MUL_END on that cycle (ready_o after edge 2).
//   - If either magnitude==0, the FSM goes MUL_FREE->MUL_END directly with result 0 (ready after edge 1).
//  Not defined: always exactly 4 MUL_ON cycles. Results are bit-identical either way.
// STRUCTURE
//  define.v gains:
//   - `MulFree/`MulOn/`MulEnd
//   - `MulStart/`MulStop
//   - `MulResultReady/`MulResultNotReady
//  Sub-module mul16x16: combinational unsigned 16x16->32 multiplier. One instance; operand halves are muxed by cnt.
//  FSM, operand/sign latch and accumulator stay in mul_seq.
// TESTING
//  - unsigned 0xFFFFFFFF*0xFFFFFFFF, start held -> ready_o=1 after edge 5, result_o=0xFFFFFFFE_00000001.
//  - signed -3*7 -> result_o=0xFFFFFFFF_FFFFFFEB.
//    signed 0x80000000*0x80000000 -> 0x40000000_00000000.
//  - unsigned 0x80000000*2 with signed_mul_i=0 -> 0x00000001_00000000; checks no spurious negation.
//  - annul_i=1 on the 2nd MUL_ON cycle -> ready_o stays 0, result_o=0, state MUL_FREE.
//    A following start 0x1234*0x10 -> 0x12340.
//  - hold start_i 3 cycles past ready -> result_o stable.
//    Drop start_i -> next cycle ready_o=0, result_o=0.
//    rst mid-op -> all outputs 0 next cycle.
//  - with `MUL_EARLY_OUT_EN: 5*6 -> 30 ready after edge 2; 0*x -> 0 ready after edge 1.
//    Without the macro: both cases ready after edge 5.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// rtl/mul_seq_pkg.sv - shared types, handshake constants and magnitude helper for the multiply sequencer
package mul_seq_pkg;

  typedef enum logic [1:0] {
    MUL_FREE = 2'b00,
    MUL_ON   = 2'b01,
    MUL_END  = 2'b10
  } mul_state_e;

  localparam logic MUL_START            = 1'b1;
  localparam logic MUL_STOP             = 1'b0;
  localparam logic MUL_RESULT_READY     = 1'b1;
  localparam logic MUL_RESULT_NOT_READY = 1'b0;

  // Two's-complement magnitude; only negated for signed operands with bit 31 set.
  function automatic logic [31:0] abs_mag(input logic [31:0] x, input logic signed_en);
    return (signed_en && x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/mul_seq_mul16x16.sv
// rtl/mul_seq_mul16x16.sv - combinational unsigned 16x16->32 partial-product multiplier
module mul16x16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [31:0] p_o
);

  assign p_o = 32'(a_i) * 32'(b_i);

endmodule

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - 4-cycle 32x32 multiply sequencer; optional MUL_EARLY_OUT_EN shortens small/zero operands
module mul_seq
  import mul_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_mul_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  mul_state_e  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] result_q, result_d;
  logic [31:0] mag_a_q, mag_a_d;
  logic [31:0] mag_b_q, mag_b_d;
  logic        neg_q, neg_d;
  logic        ready_q, ready_d;

  logic [31:0] in_mag_a, in_mag_b;
  logic [15:0] pp_a, pp_b;
  logic [31:0] pp_raw;
  logic [63:0] pp, sum;
  logic        last_step;
  logic        in_zero;

  assign in_mag_a = abs_mag(opdata1_i, signed_mul_i);
  assign in_mag_b = abs_mag(opdata2_i, signed_mul_i);

  mul16x16 u_mul16x16 (
    .a_i (pp_a),
    .b_i (pp_b),
    .p_o (pp_raw)
  );

  // Select operand halves and alignment of the partial product for this step
  always_comb begin
    pp_a = mag_a_q[15:0];
    pp_b = mag_b_q[15:0];
    pp   = 64'd0;
    case (cnt_q)
      2'd0: begin
        pp = {32'd0, pp_raw};
      end
      2'd1: begin
        pp_a = mag_a_q[31:16];
        pp   = {16'd0, pp_raw, 16'd0};
      end
      2'd2: begin
        pp_b = mag_b_q[31:16];
        pp   = {16'd0, pp_raw, 16'd0};
      end
      default: begin
        pp_a = mag_a_q[31:16];
        pp_b = mag_b_q[31:16];
        pp   = {pp_raw, 32'd0};
      end
    endcase
    sum = acc_q + pp;
  end

  // Decide whether this MUL_ON cycle completes the product, and whether an operand is zero
  always_comb begin
    last_step = (cnt_q == 2'd3);
    in_zero   = 1'b0;
`ifdef MUL_EARLY_OUT_EN
    if (cnt_q == 2'd0 && mag_a_q[31:16] == 16'd0 && mag_b_q[31:16] == 16'd0) begin
      last_step = 1'b1;
    end
    in_zero = (in_mag_a == 32'd0) || (in_mag_b == 32'd0);
`endif
  end

  // State register and datapath flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MUL_FREE;
      cnt_q    <= 2'd0;
      acc_q    <= 64'd0;
      result_q <= 64'd0;
      mag_a_q  <= 32'd0;
      mag_b_q  <= 32'd0;
      neg_q    <= 1'b0;
      ready_q  <= MUL_RESULT_NOT_READY;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      neg_q    <= neg_d;
      ready_q  <= ready_d;
    end
  end

  // Next-state logic; a flush always returns to MUL_FREE
  always_comb begin
    state_d = state_q;
    if (annul_i) begin
      state_d = MUL_FREE;
    end else begin
      case (state_q)
        MUL_FREE: if (start_i == MUL_START) state_d = in_zero ? MUL_END : MUL_ON;
        MUL_ON:   if (last_step) state_d = MUL_END;
        MUL_END:  if (start_i == MUL_STOP) state_d = MUL_FREE;
        default:  state_d = MUL_FREE;
      endcase
    end
  end

  // Output and datapath next values: latch operands, accumulate, register the final product
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    neg_d    = neg_q;
    ready_d  = ready_q;
    if (annul_i) begin
      cnt_d    = 2'd0;
      acc_d    = 64'd0;
      result_d = 64'd0;
      ready_d  = MUL_RESULT_NOT_READY;
    end else begin
      case (state_q)
        MUL_FREE: begin
          result_d = 64'd0;
          ready_d  = MUL_RESULT_NOT_READY;
          if (start_i == MUL_START) begin
            mag_a_d = in_mag_a;
            mag_b_d = in_mag_b;
            neg_d   = signed_mul_i & (opdata1_i[31] ^ opdata2_i[31]);
            acc_d   = 64'd0;
            cnt_d   = 2'd0;
            if (in_zero) ready_d = MUL_RESULT_READY;
          end
        end
        MUL_ON: begin
          acc_d = sum;
          cnt_d = cnt_q + 2'd1;
          if (last_step) begin
            result_d = neg_q ? (~sum + 64'd1) : sum;
            ready_d  = MUL_RESULT_READY;
          end
        end
        MUL_END: begin
          if (start_i == MUL_STOP) begin
            result_d = 64'd0;
            ready_d  = MUL_RESULT_NOT_READY;
          end
        end
        default: begin
          result_d = 64'd0;
          ready_d  = MUL_RESULT_NOT_READY;
        end
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - randomized self-checking bench for mul_seq against an arithmetic product model
module tb_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_mul;
  logic [31:0] opa, opb;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int pass_cnt = 0;
  int total_cnt = 0;

  mul_seq dut (
    .clk          (clk),
    .rst          (rst),
    .signed_mul_i (signed_mul),
    .opdata1_i    (opa),
    .opdata2_i    (opb),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa, sb;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic [31:0] ma, mb;
    bit early;
    early = 0;
`ifdef MUL_EARLY_OUT_EN
    early = 1;
`endif
    ma = (sgn && a[31]) ? (32'd0 - a) : a;
    mb = (sgn && b[31]) ? (32'd0 - b) : b;
    if (early && (ma == 0 || mb == 0)) return 1;
    if (early && ma < 32'h10000 && mb < 32'h10000) return 2;
    return 5;
  endfunction

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                       output logic [63:0] res, output int edges);
    @(negedge clk);
    opa = a; opb = b; signed_mul = sgn; start = 1'b1;
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (!ready && edges < 20);
    res = result;
  endtask

  task automatic op_and_check(input string name, input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic [63:0] r, e;
    int edges, el;
    e = model(a, b, sgn);
    el = exp_lat(a, b, sgn);
    do_op(a, b, sgn, r, edges);
    total_cnt++;
    if (r !== e || ready !== 1'b1)
      $display("FAIL %s result: got %h ready=%b, expected %h", name, r, ready, e);
    else pass_cnt++;
    total_cnt++;
    if (edges !== el) $display("FAIL %s latency: got %0d edges, expected %0d", name, edges, el);
    else pass_cnt++;
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (ready !== 1'b0 || result !== 64'd0)
      $display("FAIL %s release: got ready=%b result=%h, expected 0/0", name, ready, result);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_mul = 1'b0; opa = '0; opb = '0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (ready !== 1'b0 || result !== 64'd0)
      $display("FAIL reset: got ready=%b result=%h, expected 0/0", ready, result);
    else pass_cnt++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed;
    op_and_check("umax",     32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    op_and_check("neg3x7",   32'hFFFFFFFD, 32'd7,        1'b1);
    op_and_check("minxmin",  32'h80000000, 32'h80000000, 1'b1);
    op_and_check("u80x2",    32'h80000000, 32'd2,        1'b0);
    op_and_check("s5xneg6",  32'd5,        32'hFFFFFFFA, 1'b1);
    total_cnt++;
    if (model(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0) !== 64'hFFFFFFFE_00000001)
      $display("FAIL model_umax: got %h, expected fffffffe00000001", model(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0));
    else pass_cnt++;
  endtask

  task automatic test_early;
    op_and_check("small5x6", 32'd5, 32'd6, 1'b0);
    op_and_check("zero_a",   32'd0, 32'h89ABCDEF, 1'b1);
    op_and_check("zero_b",   32'h12345678, 32'd0, 1'b0);
  endtask

  task automatic test_annul;
    @(negedge clk);
    opa = 32'hDEADBEEF; opb = 32'h01234567; signed_mul = 1'b0; start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); annul = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (ready !== 1'b0 || result !== 64'd0)
      $display("FAIL annul: got ready=%b result=%h, expected 0/0", ready, result);
    else pass_cnt++;
    @(negedge clk); annul = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    total_cnt++;
    if (ready !== 1'b0 || result !== 64'd0)
      $display("FAIL annul_idle: got ready=%b result=%h, expected 0/0", ready, result);
    else pass_cnt++;
    op_and_check("after_annul", 32'h1234, 32'h10, 1'b0);
  endtask

  task automatic test_hold;
    logic [63:0] r, e;
    int edges;
    e = model(32'hCAFEF00D, 32'h87654321, 1'b1);
    do_op(32'hCAFEF00D, 32'h87654321, 1'b1, r, edges);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total_cnt++;
      if (ready !== 1'b1 || result !== e)
        $display("FAIL hold_%0d: got ready=%b result=%h, expected 1/%h", i, ready, result, e);
      else pass_cnt++;
    end
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (ready !== 1'b0 || result !== 64'd0)
      $display("FAIL hold_drop: got ready=%b result=%h, expected 0/0", ready, result);
    else pass_cnt++;
  endtask

  task automatic test_ready_pulse;
    logic [63:0] e;
    int edges;
    e = model(32'h00ABCDEF, 32'hFEDCBA98, 1'b0);
    @(negedge clk);
    opa = 32'h00ABCDEF; opb = 32'hFEDCBA98; signed_mul = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0; opa = 32'h11111111; opb = 32'h22222222;
    edges = 1;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (!ready && edges < 20);
    total_cnt++;
    if (ready !== 1'b1 || result !== e || edges !== 5)
      $display("FAIL pulse_result: got ready=%b result=%h edges=%0d, expected 1/%h/5", ready, result, edges, e);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (ready !== 1'b0 || result !== 64'd0)
      $display("FAIL pulse_width: got ready=%b result=%h, expected 0/0", ready, result);
    else pass_cnt++;
  endtask

  task automatic test_rst_midop;
    logic [63:0] r;
    int edges;
    @(negedge clk);
    opa = 32'h76543210; opb = 32'h0F0F0F0F; signed_mul = 1'b0; start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (ready !== 1'b0 || result !== 64'd0)
      $display("FAIL rst_midop: got ready=%b result=%h, expected 0/0", ready, result);
    else pass_cnt++;
    @(negedge clk); rst = 1'b0; start = 1'b0;
    do_op(32'h76543210, 32'h0F0F0F0F, 1'b0, r, edges);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (ready !== 1'b0 || result !== 64'd0)
      $display("FAIL rst_in_end: got ready=%b result=%h, expected 0/0", ready, result);
    else pass_cnt++;
    @(negedge clk); rst = 1'b0; start = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    logic sgn;
    for (int i = 0; i < 40; i++) begin
      a = $urandom; b = $urandom; sgn = 1'($urandom);
      case ($urandom_range(0, 3))
        0: begin a = a & 32'h0000FFFF; b = b & 32'h0000FFFF; end
        1: a = (i % 2 == 0) ? 32'd0 : 32'hFFFF0000 | a;
        default: ;
      endcase
      op_and_check($sformatf("rand_%0d", i), a, b, sgn);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_early();
    test_annul();
    test_hold();
    test_ready_pulse();
    test_rst_midop();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
